// File: rtl/lsu_pkg.sv
// Shared types and constants for the sub-word load/store controller.
// The build macro LSU_MISALIGN_TRAP_EN is consumed by lsu_subword_ctrl.
package lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        WRITE  = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only have signed-width codes; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load data, and merges
// byte/halfword store data into a fetched word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [1:0]        i_off,
    input  logic [2:0]        i_funct3,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes use only off[1]; misalignment is filtered upstream.
    assign w_byte = i_word[{i_off, 3'b000} +: 8];
    assign w_half = i_word[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_load = '0;
        case (i_funct3)
            F3_B:    o_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            F3_BU:   o_load = {{(DATA_W-8){1'b0}}, w_byte};
            F3_H:    o_load = {{(DATA_W-16){w_half[15]}}, w_half};
            F3_HU:   o_load = {{(DATA_W-16){1'b0}}, w_half};
            F3_W:    o_load = i_word;
            default: o_load = '0;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_funct3)
            F3_B:    o_merge[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
            F3_H:    o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// RV32I load/store controller in front of a word-only DataMem; SB/SH are
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_subword_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        o_dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and resp_valid pulses for one cycle in RESP.

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_misalign;
    logic              w_bad;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: w_misalign = (req_addr[1:0] == 2'b11);
            F3_W:        w_misalign = (req_addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_bad = !f3_legal(req_we, req_funct3) || w_misalign;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane (
        .i_word   (mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_bad)                    w_next = RESP;
                    else if (!req_we)             w_next = LOAD;
                    else if (req_funct3 == F3_W)  w_next = WRITE;
                    else                          w_next = RMW_RD;
                end
            end
            LOAD:    w_next = RESP;
            RMW_RD:  w_next = RMW_WR;
            RMW_WR:  w_next = RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The merge is folded into the RMW_RD capture, so RMW_WR drives a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_wdata     <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= {req_addr[ADDR_W-1:2], 2'b00};
                        r_off       <= req_addr[1:0];
                        r_funct3    <= req_funct3;
                        r_wdata     <= req_wdata;
                        r_mem_wdata <= req_wdata;
                        if (w_bad) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_rdata <= w_load;
                    r_err   <= 1'b0;
                end
                RMW_RD: r_mem_wdata <= w_merge;
                RMW_WR, WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign resp_valid  = (r_state == RESP);
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign mem_we      = (r_state == WRITE) || (r_state == RMW_WR);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a small word-wide DataMem model.
module tb_lsu_subword_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] mem [0:63];

    int errors;
    int checks;

    int          lat;
    int          we_cnt;
    int          waited;
    logic [31:0] w_addr_seen;
    logic [31:0] w_data_seen;
    logic [31:0] r_data_seen;
    logic        err_seen;

    lsu_subword_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issues one request and records what the DUT does up to and including RESP.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        bit acc;
        acc         = 1'b0;
        waited      = 0;
        lat         = 0;
        we_cnt      = 0;
        w_addr_seen = '0;
        w_data_seen = '0;
        r_data_seen = '0;
        err_seen    = 1'b0;
        req_valid   = 1'b1;
        req_we      = we;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wd;
        for (int i = 0; i < 8 && !acc; i++) begin
            if (req_ready) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        #1 req_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got no accept, required accept within 8 cycles", addr);
        end else begin
            for (int k = 1; k <= 10 && lat == 0; k++) begin
                @(negedge clk);
                if (mem_we) begin
                    we_cnt++;
                    w_addr_seen = mem_addr;
                    w_data_seen = mem_wdata;
                end
                if (resp_valid) begin
                    lat         = k;
                    r_data_seen = resp_rdata;
                    err_seen    = resp_err;
                end
            end
            if (lat == 0) begin
                errors++;
                $display("FAIL resp_timeout addr=%h got no resp_valid, required within 10 cycles", addr);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_sw();
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_lat got %0d exp 2", lat); end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL sw_we_cnt got %0d exp 1", we_cnt); end
        checks++; if (w_addr_seen !== 32'h10) begin errors++; $display("FAIL sw_addr got %h exp 00000010", w_addr_seen); end
        checks++; if (w_data_seen !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got %h exp deadbeef", w_data_seen); end
        checks++; if (err_seen !== 1'b0 || r_data_seen !== 32'h0) begin errors++; $display("FAIL sw_resp got err=%b rdata=%h exp err=0 rdata=0", err_seen, r_data_seen); end
    endtask

    task automatic test_loads();
        run_req(1'b0, 3'b000, 32'h13, 32'h0);
        checks++; if (r_data_seen !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb13 got %h exp ffffffde", r_data_seen); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lb13_lat got %0d exp 2", lat); end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL lb13_we got %0d exp 0", we_cnt); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL lb13_err got %b exp 0", err_seen); end
        run_req(1'b0, 3'b100, 32'h13, 32'h0);
        checks++; if (r_data_seen !== 32'h000000DE) begin errors++; $display("FAIL lbu13 got %h exp 000000de", r_data_seen); end
        run_req(1'b0, 3'b101, 32'h12, 32'h0);
        checks++; if (r_data_seen !== 32'h0000DEAD) begin errors++; $display("FAIL lhu12 got %h exp 0000dead", r_data_seen); end
        run_req(1'b0, 3'b001, 32'h10, 32'h0);
        checks++; if (r_data_seen !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh10 got %h exp ffffbeef", r_data_seen); end
        run_req(1'b0, 3'b000, 32'h10, 32'h0);
        checks++; if (r_data_seen !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb10 got %h exp ffffffef", r_data_seen); end
        run_req(1'b0, 3'b100, 32'h11, 32'h0);
        checks++; if (r_data_seen !== 32'h000000BE) begin errors++; $display("FAIL lbu11 got %h exp 000000be", r_data_seen); end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (r_data_seen !== 32'hDEADBEEF) begin errors++; $display("FAIL lw10 got %h exp deadbeef", r_data_seen); end
    endtask

    task automatic test_subword_store();
        run_req(1'b1, 3'b000, 32'h11, 32'h00000055);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sb_lat got %0d exp 3", lat); end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL sb_we_cnt got %0d exp 1", we_cnt); end
        checks++; if (w_addr_seen !== 32'h10) begin errors++; $display("FAIL sb_addr got %h exp 00000010", w_addr_seen); end
        checks++; if (w_data_seen !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_data got %h exp dead55ef", w_data_seen); end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (r_data_seen !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_readback got %h exp dead55ef", r_data_seen); end
        run_req(1'b1, 3'b001, 32'h12, 32'hABCD1234);
        checks++; if (lat !== 3) begin errors++; $display("FAIL sh_lat got %0d exp 3", lat); end
        checks++; if (w_data_seen !== 32'h123455EF) begin errors++; $display("FAIL sh_data got %h exp 123455ef", w_data_seen); end
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL restore_mem got %h exp deadbeef", mem[4]); end
    endtask

    task automatic test_misalign();
        run_req(1'b1, 3'b010, 32'h12, 32'hDEADBEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL sw12_err got %b exp 1", err_seen); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL sw12_lat got %0d exp 1", lat); end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL sw12_we got %0d exp 0", we_cnt); end
        run_req(1'b0, 3'b001, 32'h13, 32'h0);
        checks++; if (err_seen !== 1'b1 || r_data_seen !== 32'h0) begin errors++; $display("FAIL lh13 got err=%b rdata=%h exp err=1 rdata=0", err_seen, r_data_seen); end
`else
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL sw12_err got %b exp 0", err_seen); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw12_lat got %0d exp 2", lat); end
        checks++; if (we_cnt !== 1 || w_addr_seen !== 32'h10) begin errors++; $display("FAIL sw12_write got cnt=%0d addr=%h exp cnt=1 addr=00000010", we_cnt, w_addr_seen); end
        run_req(1'b0, 3'b001, 32'h13, 32'h0);
        checks++; if (err_seen !== 1'b0 || r_data_seen !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh13 got err=%b rdata=%h exp err=0 rdata=ffffdead", err_seen, r_data_seen); end
`endif
    endtask

    task automatic test_illegal();
        run_req(1'b0, 3'b011, 32'h20, 32'h0);
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL ill_ld_err got %b exp 1", err_seen); end
        checks++; if (r_data_seen !== 32'h0) begin errors++; $display("FAIL ill_ld_rdata got %h exp 0", r_data_seen); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ill_ld_lat got %0d exp 1", lat); end
        run_req(1'b1, 3'b100, 32'h10, 32'h0);
        checks++; if (err_seen !== 1'b1 || we_cnt !== 0) begin errors++; $display("FAIL ill_st got err=%b we=%0d exp err=1 we=0", err_seen, we_cnt); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL ill_st_mem got %h exp deadbeef", mem[4]); end
    endtask

    task automatic test_back_to_back();
        run_req(1'b0, 3'b100, 32'h12, 32'h0);
        checks++; if (r_data_seen !== 32'h000000AD) begin errors++; $display("FAIL b2b_first got %h exp 000000ad", r_data_seen); end
        run_req(1'b0, 3'b101, 32'h10, 32'h0);
        checks++; if (waited !== 1) begin errors++; $display("FAIL b2b_wait got %0d exp 1", waited); end
        checks++; if (r_data_seen !== 32'h0000BEEF) begin errors++; $display("FAIL b2b_second got %h exp 0000beef", r_data_seen); end
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h10;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD1234) begin errors++; $display("FAIL rmw_wr got we=%b data=%h exp we=1 data=dead1234", mem_we, mem_wdata); end
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b exp 0", mem_we); end
        @(posedge clk);
        #1;
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mem got %h exp deadbeef", mem[4]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, resp_valid); end
        run_req(1'b0, 3'b010, 32'h10, 32'h0);
        checks++; if (r_data_seen !== 32'hDEADBEEF || we_cnt !== 0) begin errors++; $display("FAIL post_rst_lw got %h we=%0d exp deadbeef we=0", r_data_seen, we_cnt); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sw();
        test_loads();
        test_subword_store();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
Load/store controller sitting directly upstream of DataMem. It accepts RV32I load/store requests from the execute stage, drives DataMem's word-wide port, and sign- or zero-extends LB/LH/LBU/LHU results. Because DataMem only writes whole words, SB/SH are done as read-modify-write. Multi-cycle: the core stalls on req_ready low.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; only 32 is supported

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores
resp_err  out  1  illegal funct3 or misaligned (see Optional Feature); qualified by resp_valid
mem_we  out  1  DataMem we
mem_addr  out  ADDR_W  DataMem addr, always word-aligned ({addr[31:2],2'b00})
mem_wdata  out  DATA_W  DataMem data_i
mem_rdata  in  DATA_W  DataMem data_o (combinational read, valid when mem_we=0)

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. All registered outputs clear: resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wdata=0. req_ready=1 after rst deasserts.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. On acceptance, addr, we, funct3 and wdata are captured. req_valid in any non-IDLE state is ignored.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code goes IDLE->RESP with resp_err=1 and no mem_we.
- Lane: off = addr[1:0].
  - Byte extract: rdata[8*off+7 -> 8*off].
  - Halfword extract: rdata[16*off[1]+15 -> 16*off[1]].
- States:
  - IDLE -> LOAD (load) | WRITE (SW) | RMW_RD (SB/SH) | RESP (error).
  - LOAD: mem_we=0, mem_addr driven. Edge captures the extended result, then -> RESP.
  - RMW_RD: mem_we=0. Edge captures mem_rdata into the merge register, then -> RMW_WR.
  - RMW_WR: mem_we=1; mem_wdata = captured word with the target byte/halfword lane replaced by req_wdata[7:0] or [15:0]. Then -> RESP.
  - WRITE: mem_we=1, mem_wdata=req_wdata. Then -> RESP.
  - RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Latency, counting from the acceptance edge to the resp_valid cycle:
  - load, SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- Throughput: next request accepted in the cycle after RESP, since req_ready is high in IDLE.
- mem_we is high in exactly one cycle per store and is never high for loads or errors.
- resp_rdata holds its value until the next RESP. Stores load 0.
- Reset mid-operation (e.g., in RMW_WR): mem_we drops immediately (asynchronously). The store is abandoned and no partial write completes afterwards.
- Address wrap: none. The aligned address is passed through unchanged.

Optional Feature:
Macro: LSU_MISALIGN_TRAP_EN
- Defined: LH/LHU/SH with off==3, or LW/SW with off!=0, go IDLE->RESP with resp_err=1. There is no memory access.
- Undefined: misalignment is not checked. Low address bits beyond the access size are ignored: halfword uses off[1], word uses lane 0. resp_err is set only for illegal funct3.

Decomposition:
- Package lsu_pkg holds:
  - state enum: IDLE, LOAD, RMW_RD, RMW_WR, WRITE, RESP
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - ADDR_W/DATA_W defaults
- Sub-module lsu_lane_align (combinational) holds lane extract/extend and lane merge. The FSM and registers stay in lsu_subword_ctrl.

Test Plan:
- Memory word 0x10 = 0xDEADBEEF; LB addr 0x13 -> resp_rdata=0xFFFFFFDE, resp_valid 2 cycles after accept, mem_we never 1.
- Same memory; LBU 0x13 -> 0x000000DE; LHU 0x12 -> 0x0000DEAD; LH 0x10 -> 0xFFFFBEEF.
- SB addr 0x11, wdata 0x00000055 -> one read cycle, then mem_we=1 with mem_addr=0x10, mem_wdata=0xDEAD55EF; resp_valid 3 cycles after accept; a following LW 0x10 returns 0xDEAD55EF.
- SW addr 0x12 (trap defined) -> resp_err=1 one cycle after accept, mem_we never 1. With the macro undefined: write 0x10 with wdata, resp_err=0.
- Illegal funct3=011, load at 0x20 -> resp_err=1, resp_rdata=0.
- Assert rst during RMW_WR of SH 0x10 -> mem_we=0 the same cycle, memory unchanged at 0xDEADBEEF, req_ready=1 after release.
